// File: rtl/axis_deci_boxcar_if.sv
// Sample stream bundle (tdata/tvalid, no backpressure) shared by the boxcar decimator's input and output.
interface axis_deci_boxcar_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_deci_boxcar.sv
// Boxcar decimator: averages 2^k valid samples and strobes next_dv once per block.
// Optional AXIS_DECI_BOXCAR_ROUND_EN selects round-half-up instead of floor for the mean.
module axis_deci_boxcar #(
  parameter int SAXIS_TDATA_WIDTH = 16,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int DECI_LOG2_MAX     = 8
) (
  input  logic                     a_clk,
  input  logic                     a_resetn,
  axis_deci_boxcar_if.slave        S_AXIS,
  input  logic                     enable,
  input  logic [3:0]               deci_log2,
  axis_deci_boxcar_if.master       M_AXIS,
  output logic                     next_dv,
  output logic [DECI_LOG2_MAX:0]   blk_count
);

  localparam int ACC_W = SAXIS_TDATA_WIDTH + DECI_LOG2_MAX;
  localparam int CW    = DECI_LOG2_MAX + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                          state;
  logic signed [ACC_W-1:0]         acc;
  logic [CW-1:0]                   cnt;
  logic [3:0]                      k_reg;

  logic [3:0]                      k_in;
  logic [CW-1:0]                   cnt_last;
  logic signed [ACC_W-1:0]         samp_ext;
  logic signed [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W-1:0]         rounded;
  logic signed [SAXIS_TDATA_WIDTH-1:0] mean_s;

  always_comb begin
    k_in     = (int'(deci_log2) > DECI_LOG2_MAX) ? 4'(DECI_LOG2_MAX) : deci_log2;
    cnt_last = CW'((1 << k_reg) - 1);
    samp_ext = ACC_W'($signed(S_AXIS.tdata));
    acc_sum  = acc + samp_ext;
`ifdef AXIS_DECI_BOXCAR_ROUND_EN
    // Bias of half an LSB of the result; fits in ACC_W since the mean stays in input range.
    rounded  = acc_sum + ((k_reg == 4'd0) ? '0 : (ACC_W'(1) << (k_reg - 4'd1)));
`else
    rounded  = acc_sum;
`endif
    mean_s   = SAXIS_TDATA_WIDTH'(rounded >>> k_reg);
  end

  assign blk_count = cnt;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      k_reg         <= '0;
      next_dv       <= 1'b0;
      M_AXIS.tdata  <= '0;
      M_AXIS.tvalid <= 1'b0;
    end else if (!enable) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      next_dv       <= 1'b0;
      M_AXIS.tvalid <= 1'b0;
    end else begin
      next_dv <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= ACCUM;
          k_reg <= k_in;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          if (S_AXIS.tvalid) begin
            if (cnt == cnt_last) begin
              M_AXIS.tdata  <= MAXIS_TDATA_WIDTH'(mean_s);
              M_AXIS.tvalid <= 1'b1;
              next_dv       <= 1'b1;
              state         <= EMIT;
              acc           <= '0;
              cnt           <= '0;
            end else begin
              acc <= acc_sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          // The EMIT-cycle sample opens the next block; with a fresh k=0 it completes it too.
          k_reg <= k_in;
          state <= ACCUM;
          acc   <= '0;
          cnt   <= '0;
          if (S_AXIS.tvalid) begin
            if (k_in == 4'd0) begin
              M_AXIS.tdata  <= MAXIS_TDATA_WIDTH'($signed(S_AXIS.tdata));
              M_AXIS.tvalid <= 1'b1;
              next_dv       <= 1'b1;
              state         <= EMIT;
            end else begin
              acc <= samp_ext;
              cnt <= CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_deci_boxcar.sv
// Scoreboard bench for axis_deci_boxcar: block-level reference model feeds an expected-mean queue.
module tb_axis_deci_boxcar;

  logic        a_clk = 1'b0;
  logic        a_resetn;
  logic        enable;
  logic [3:0]  deci_log2;
  logic        next_dv;
  logic [8:0]  blk_count;

  axis_deci_boxcar_if #(.W(16)) s_if ();
  axis_deci_boxcar_if #(.W(32)) m_if ();

  axis_deci_boxcar #(
    .SAXIS_TDATA_WIDTH (16),
    .MAXIS_TDATA_WIDTH (32),
    .DECI_LOG2_MAX     (8)
  ) dut (
    .a_clk     (a_clk),
    .a_resetn  (a_resetn),
    .S_AXIS    (s_if),
    .enable    (enable),
    .deci_log2 (deci_log2),
    .M_AXIS    (m_if),
    .next_dv   (next_dv),
    .blk_count (blk_count)
  );

  always #5 a_clk = ~a_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: samples of the open block, its length, expected means.
  int blk[$];
  int n_blk     = 1;
  bit fresh     = 1'b1;
  bit relatch   = 1'b0;
  bit tv_exp    = 1'b0;
  int exp_q[$];
  int last_data = 0;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mean_of(int s, int n);
    int q;
`ifdef AXIS_DECI_BOXCAR_ROUND_EN
    if (n > 1) s = s + n / 2;
`endif
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_step(bit en, bit v, int d, int dl);
    int kk;
    int sum;
    kk = (dl > 8) ? 8 : dl;
    if (!en) begin
      blk.delete();
      fresh   = 1'b1;
      relatch = 1'b0;
      tv_exp  = 1'b0;
      return;
    end
    if (fresh) begin
      n_blk = 1 << kk;
      fresh = 1'b0;
      return;
    end
    if (relatch) begin
      n_blk   = 1 << kk;
      relatch = 1'b0;
    end
    if (v) begin
      blk.push_back(d);
      if (blk.size() == n_blk) begin
        sum = 0;
        foreach (blk[i]) sum += blk[i];
        exp_q.push_back(mean_of(sum, n_blk));
        tv_exp  = 1'b1;
        relatch = 1'b1;
        blk.delete();
      end
    end
  endtask

  // Drive one clock's worth of inputs (called just after a falling edge).
  task automatic cycle(bit en, bit v, logic [15:0] d, logic [3:0] dl);
    enable       = en;
    s_if.tvalid  = v;
    s_if.tdata   = d;
    deci_log2    = dl;
    model_step(en, v, int'($signed(d)), int'(dl));
    @(negedge a_clk);
  endtask

  task automatic do_reset();
    a_resetn = 1'b0;
    #1;
    chk("rst_tdata", int'(m_if.tdata), 0);
    chk("rst_tvalid", int'(m_if.tvalid), 0);
    chk("rst_next_dv", int'(next_dv), 0);
    chk("rst_blk_count", int'(blk_count), 0);
    blk.delete();
    exp_q.delete();
    fresh     = 1'b1;
    relatch   = 1'b0;
    tv_exp    = 1'b0;
    last_data = 0;
    @(negedge a_clk);
    a_resetn = 1'b1;
  endtask

  task automatic start(logic [3:0] dl);
    cycle(1'b0, 1'b0, 16'h0, dl);
    cycle(1'b1, 1'b0, 16'h0, dl);
  endtask

  task automatic run_block(logic [3:0] dl, int n, int base);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 16'(base + i), dl);
  endtask

  // Monitor: compares DUT outputs after each rising edge against the model.
  initial begin
    int e;
    forever begin
      @(posedge a_clk);
      #1;
      chk("tvalid", int'(m_if.tvalid), int'(tv_exp));
      chk("blk_count", int'(blk_count), blk.size());
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("next_dv", int'(next_dv), 1);
        chk("mean", int'($signed(m_if.tdata)), e);
        last_data = e;
      end else begin
        chk("next_dv", int'(next_dv), 0);
        chk("hold_tdata", int'($signed(m_if.tdata)), last_data);
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdl;
    bit          ren;
    a_resetn    = 1'b0;
    enable      = 1'b0;
    deci_log2   = 4'd0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    @(negedge a_clk);
    do_reset();

    // Reset in the middle of a k=2 block, then a clean block.
    start(4'd2);
    run_block(4'd2, 3, 100);
    do_reset();
    cycle(1'b1, 1'b0, 16'h0, 4'd2);
    run_block(4'd2, 4, 1);

    // k=2 continuous 1..8.
    start(4'd2);
    run_block(4'd2, 8, 1);

    // k=3 negative and small sums.
    start(4'd3);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'hFFFF, 4'd3);
    cycle(1'b1, 1'b1, 16'hFFFD, 4'd3);
    cycle(1'b1, 1'b1, 16'hFFFC, 4'd3);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 16'h0, 4'd3);
    cycle(1'b1, 1'b1, 16'd4, 4'd3);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 16'h0, 4'd3);

    // k=1 with gaps.
    start(4'd1);
    cycle(1'b1, 1'b1, 16'd10, 4'd1);
    cycle(1'b1, 1'b0, 16'd77, 4'd1);
    cycle(1'b1, 1'b1, 16'd20, 4'd1);
    cycle(1'b1, 1'b0, 16'd99, 4'd1);

    // k=0 pass-through with extremes.
    start(4'd0);
    cycle(1'b1, 1'b1, 16'h7FFF, 4'd0);
    cycle(1'b1, 1'b1, 16'h8000, 4'd0);
    cycle(1'b1, 1'b1, 16'd1, 4'd0);
    cycle(1'b1, 1'b1, 16'd2, 4'd0);
    cycle(1'b1, 1'b1, 16'd3, 4'd0);

    // deci_log2 change mid-block, then clamp, then enable drop on the last sample.
    start(4'd2);
    run_block(4'd2, 2, 40);
    run_block(4'd1, 6, 50);
    start(4'd15);
    run_block(4'd15, 256, -128);
    start(4'd2);
    run_block(4'd2, 3, 7);
    cycle(1'b0, 1'b1, 16'd9, 4'd2);
    cycle(1'b0, 1'b0, 16'd0, 4'd2);

    // Randomized traffic.
    start(4'd1);
    rdl = 4'd1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) rdl = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0:       rd = 16'h7FFF;
        1:       rd = 16'h8000;
        default: rd = 16'($urandom);
      endcase
      ren = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cycle(ren, ($urandom_range(0, 9) < 7), rd, rdl);
    end

    cycle(1'b1, 1'b0, 16'h0, rdl);
    cycle(1'b0, 1'b0, 16'h0, rdl);
    cycle(1'b0, 1'b0, 16'h0, rdl);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
